// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit registers, two combinational read
// ports and one synchronous write port. x0 reads as zero and ignores writes.
// finish_flag freezes the array at end of program while reads keep working.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] Read1,
   input  logic [ADDR_WIDTH-1:0] Read2,
   input  logic [ADDR_WIDTH-1:0] RD,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   input  logic                  finish_flag,
   output logic [DATA_WIDTH-1:0] Data1,
   output logic [DATA_WIDTH-1:0] Data2
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  wr_en;

   // A write is only allowed when enabled, not frozen, and not aimed at x0.
   always_comb begin
      wr_en = 1'b0;
      if (RegWrite && !finish_flag && (RD != ZERO_ADDR)) begin
         wr_en = 1'b1;
      end else begin
         wr_en = 1'b0;
      end
   end

   // Next-state array: every entry holds except the single addressed one.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[RD] = WriteData;
      end else begin
         regs_d = regs_q;
      end
   end

   // Register array; reset clears everything immediately and wins over a write edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= ZERO_DATA;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read port 1: no write bypass, x0 forced to zero regardless of array contents.
   always_comb begin
      Data1 = ZERO_DATA;
      if (Read1 == ZERO_ADDR) begin
         Data1 = ZERO_DATA;
      end else begin
         Data1 = regs_q[Read1];
      end
   end

   // Read port 2: identical to port 1 and fully independent of it.
   always_comb begin
      Data2 = ZERO_DATA;
      if (Read2 == ZERO_ADDR) begin
         Data2 = ZERO_DATA;
      end else begin
         Data2 = regs_q[Read2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a vector table replayed cycle by
// cycle through a scoreboard queue, plus hand sequences for asynchronous
// reset (mid-cycle and coincident with a write edge).
module tb_register_file;

   logic        clock;
   logic        reset_n;
   logic [4:0]  Read1;
   logic [4:0]  Read2;
   logic [4:0]  RD;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic        finish_flag;
   logic [31:0] Data1;
   logic [31:0] Data2;

   int n_checks;
   int n_fail;

   logic [63:0] sb_q [$];

   typedef struct packed {
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        we;
      logic        fin;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [18];

   register_file #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .NUM_REGS   (32)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .Read1       (Read1),
      .Read2       (Read2),
      .RD          (RD),
      .WriteData   (WriteData),
      .RegWrite    (RegWrite),
      .finish_flag (finish_flag),
      .Data1       (Data1),
      .Data2       (Data2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic [31:0] wd,
                               input logic we, input logic fin,
                               input logic [31:0] e1, input logic [31:0] e2);
      vec_t v;
      v.r1 = r1; v.r2 = r2; v.rd = rd; v.wd = wd;
      v.we = we; v.fin = fin; v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] e1, input logic [31:0] e2);
      sb_q.push_back({e1, e2});
   endtask

   task automatic sb_check(input string nm);
      logic [63:0] e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h/%h expected an entry", nm, Data1, Data2);
      end else begin
         e = sb_q.pop_front();
         check32({nm, ".Data1"}, Data1, e[63:32]);
         check32({nm, ".Data2"}, Data2, e[31:0]);
      end
   endtask

   task automatic read_pair(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [31:0] e1, input logic [31:0] e2);
      Read1 = r1;
      Read2 = r2;
      sb_push(e1, e2);
      #1;
      sb_check(nm);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset_n     = 1'b0;
      Read1       = 5'd0;
      Read2       = 5'd0;
      RD          = 5'd0;
      WriteData   = 32'h0;
      RegWrite    = 1'b0;
      finish_flag = 1'b0;

      // Expected Data1/Data2 are sampled before the vector's own write edge.
      vecs[0]  = mk(5'd3,  5'd5,  5'd3,  32'hABCDEFFF, 1'b1, 1'b0, 32'h0,        32'h0);
      vecs[1]  = mk(5'd3,  5'd5,  5'd5,  32'hFBCDE111, 1'b1, 1'b0, 32'hABCDEFFF, 32'h0);
      vecs[2]  = mk(5'd3,  5'd5,  5'd0,  32'h0,        1'b0, 1'b0, 32'hABCDEFFF, 32'hFBCDE111);
      vecs[3]  = mk(5'd7,  5'd10, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0);
      vecs[4]  = mk(5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        32'h0);
      vecs[5]  = mk(5'd0,  5'd3,  5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'hABCDEFFF);
      vecs[6]  = mk(5'd3,  5'd3,  5'd0,  32'h0,        1'b0, 1'b0, 32'hABCDEFFF, 32'hABCDEFFF);
      vecs[7]  = mk(5'd9,  5'd9,  5'd9,  32'h12345678, 1'b1, 1'b0, 32'h0,        32'h0);
      vecs[8]  = mk(5'd9,  5'd5,  5'd0,  32'h0,        1'b0, 1'b0, 32'h12345678, 32'hFBCDE111);
      vecs[9]  = mk(5'd3,  5'd9,  5'd3,  32'hDEADBEEF, 1'b1, 1'b1, 32'hABCDEFFF, 32'h12345678);
      vecs[10] = mk(5'd3,  5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 32'hABCDEFFF, 32'h0);
      vecs[11] = mk(5'd9,  5'd3,  5'd9,  32'h0,        1'b1, 1'b1, 32'h12345678, 32'hABCDEFFF);
      vecs[12] = mk(5'd9,  5'd3,  5'd9,  32'hCAFEF00D, 1'b1, 1'b0, 32'h12345678, 32'hABCDEFFF);
      vecs[13] = mk(5'd9,  5'd9,  5'd9,  32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
      vecs[14] = mk(5'd9,  5'd31, 5'd0,  32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 32'h0);
      vecs[15] = mk(5'd31, 5'd1,  5'd31, 32'h80000001, 1'b1, 1'b0, 32'h0,        32'h0);
      vecs[16] = mk(5'd31, 5'd30, 5'd0,  32'h0,        1'b0, 1'b0, 32'h80000001, 32'h0);
      vecs[17] = mk(5'd3,  5'd5,  5'd0,  32'h0,        1'b0, 1'b0, 32'hABCDEFFF, 32'hFBCDE111);

      // Power-on reset, then every register must read zero.
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 32; i++) begin
         read_pair($sformatf("por_x%0d", i), i[4:0], 5'(31 - i), 32'h0, 32'h0);
      end

      // Table: drive at the falling edge, check before the next rising edge.
      for (int i = 0; i < 18; i++) begin
         @(negedge clock);
         RD          = vecs[i].rd;
         WriteData   = vecs[i].wd;
         RegWrite    = vecs[i].we;
         finish_flag = vecs[i].fin;
         read_pair($sformatf("vec%0d", i), vecs[i].r1, vecs[i].r2, vecs[i].e1, vecs[i].e2);
      end
      @(negedge clock);
      RegWrite    = 1'b0;
      finish_flag = 1'b0;

      // Mid-cycle reset pulse: contents clear with no clock edge involved.
      @(negedge clock);
      Read1 = 5'd3;
      Read2 = 5'd5;
      #2;
      reset_n = 1'b0;
      #1;
      sb_push(32'h0, 32'h0);
      sb_check("midcycle_rst");
      @(negedge clock);
      for (int i = 0; i < 32; i++) begin
         read_pair($sformatf("rst_x%0d", i), i[4:0], i[4:0], 32'h0, 32'h0);
      end
      @(negedge clock);
      reset_n = 1'b1;

      // Write x4 normally so the lost write below is observable.
      @(negedge clock);
      RD        = 5'd4;
      WriteData = 32'h55AA55AA;
      RegWrite  = 1'b1;
      @(negedge clock);
      RegWrite  = 1'b0;
      read_pair("pre_rstwr_x4", 5'd4, 5'd0, 32'h55AA55AA, 32'h0);

      // Reset held low across a write edge: the write must be lost.
      @(negedge clock);
      RD        = 5'd4;
      WriteData = 32'h11111111;
      RegWrite  = 1'b1;
      #3;
      reset_n = 1'b0;
      @(posedge clock);
      #2;
      read_pair("rstwr_x4", 5'd4, 5'd4, 32'h0, 32'h0);
      @(negedge clock);
      RegWrite = 1'b0;
      reset_n  = 1'b1;
      read_pair("rstwr_after", 5'd4, 5'd3, 32'h0, 32'h0);

      // Writes resume normally once reset is released.
      @(negedge clock);
      RD        = 5'd6;
      WriteData = 32'h0F0F1234;
      RegWrite  = 1'b1;
      @(negedge clock);
      RegWrite  = 1'b0;
      read_pair("recover_x6", 5'd6, 5'd4, 32'h0F0F1234, 32'h0);

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_drain: got %0d leftover entries expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
